input_buffer: RTL and testbench

INPUT_BUFFER -- requirements
Module: input_buffer

---
 rtl/sobel_pkg.sv | 21 ++
 rtl/flex_counter.sv | 32 +++
 rtl/input_buffer.sv | 160 ++++++++++++++++
 tb/tb_input_buffer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel front end: reader FSM state
// encoding, packing constants and a counter-width helper.
package sobel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    UNPACK,
    DONE
  } state_t;

  localparam int PIX_PER_WORD   = 4;
  localparam int BYTES_PER_WORD = 4;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Wrap-around up counter: counts 0..i_rollover_val on i_count_en, then wraps.
// o_rollover flags that the current count equals the rollover value.
module flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_clear,
  input  logic             i_count_en,
  input  logic [WIDTH-1:0] i_rollover_val,
  output logic [WIDTH-1:0] o_count,
  output logic             o_rollover
);

  logic [WIDTH-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count_en) begin
      r_count <= (r_count == i_rollover_val) ? '0 : r_count + 1'b1;
    end
  end

  assign o_count    = r_count;
  assign o_rollover = (r_count == i_rollover_val);

endmodule

// File: rtl/input_buffer.sv
// Reads a packed 8-bit grayscale image from SRAM one word at a time and
// streams it pixel by pixel to the Sobel core. SERPENTINE_EN: odd rows right-to-left.
module input_buffer
  import sobel_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  output logic        read_req,
  output logic [31:0] read_addr,
  input  logic [31:0] read_data,
  input  logic        read_valid,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_eol,
  output logic        pix_last,
  output logic        busy,
  output logic        done
);

  localparam int COL_W         = cnt_width(IMG_W);
  localparam int ROW_W         = cnt_width(IMG_H);
  localparam int WORDS_PER_ROW = IMG_W / PIX_PER_WORD;

  state_t            r_state;
  logic [31:0]       r_base;
  logic [31:0]       r_word;
  logic              r_read_req;
  logic              r_pix_valid;
  logic              r_busy;
  logic              r_done;

  logic              w_clear;
  logic              w_xfer;
  logic [COL_W-1:0]  w_col;
  logic              w_col_roll;
  logic [ROW_W-1:0]  w_row;
  logic              w_row_roll;
  logic              w_mirror;
  logic [1:0]        w_lane;
  logic [31:0]       w_word_in_row;
  logic [31:0]       w_word_idx;

  assign w_clear = (r_state == IDLE) && start;
  assign w_xfer  = r_pix_valid && pix_ready;

  // Column counts pixels in traversal order; row advances on each row's last pixel.
  flex_counter #(.WIDTH(COL_W)) u_col_cnt (
    .clk            (clk),
    .n_rst          (n_rst),
    .i_clear        (w_clear),
    .i_count_en     (w_xfer),
    .i_rollover_val (COL_W'(IMG_W - 1)),
    .o_count        (w_col),
    .o_rollover     (w_col_roll)
  );

  flex_counter #(.WIDTH(ROW_W)) u_row_cnt (
    .clk            (clk),
    .n_rst          (n_rst),
    .i_clear        (w_clear),
    .i_count_en     (w_xfer && w_col_roll),
    .i_rollover_val (ROW_W'(IMG_H - 1)),
    .o_count        (w_row),
    .o_rollover     (w_row_roll)
  );

`ifdef SERPENTINE_EN
  assign w_mirror = w_row[0];
`else
  assign w_mirror = 1'b0;
`endif

  // Mirrored rows walk words from the right end and bytes from pixel 3 down.
  assign w_lane = w_mirror ? ~w_col[1:0] : w_col[1:0];

  always_comb begin
    w_word_in_row = 32'(w_col >> 2);
    if (w_mirror) begin
      w_word_in_row = 32'(WORDS_PER_ROW - 1) - w_word_in_row;
    end
    w_word_idx = 32'(w_row) * 32'(WORDS_PER_ROW) + w_word_in_row;
  end

  assign read_addr = r_base + w_word_idx * 32'(BYTES_PER_WORD);

  always_comb begin
    unique case (w_lane)
      2'd0:    pix_data = r_word[31:24];
      2'd1:    pix_data = r_word[23:16];
      2'd2:    pix_data = r_word[15:8];
      default: pix_data = r_word[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_word      <= '0;
      r_read_req  <= 1'b0;
      r_pix_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_base     <= base_addr;
            r_read_req <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= FETCH;
          end
        end
        FETCH: begin
          r_read_req <= 1'b0;
          r_state    <= WAIT_DATA;
        end
        WAIT_DATA: begin
          if (read_valid) begin
            r_word      <= read_data;
            r_pix_valid <= 1'b1;
            r_state     <= UNPACK;
          end
        end
        UNPACK: begin
          if (w_xfer && (w_col[1:0] == 2'd3)) begin
            r_pix_valid <= 1'b0;
            if (w_col_roll && w_row_roll) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_read_req <= 1'b1;
              r_state    <= FETCH;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign read_req  = r_read_req;
  assign pix_valid = r_pix_valid;
  assign pix_eol   = r_pix_valid && w_col_roll;
  assign pix_last  = pix_eol && w_row_roll;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_input_buffer.sv
// Bench for input_buffer: random SRAM latency and consumer backpressure, an
// image-level reference model feeding scoreboards for addresses and pixels.
module tb_input_buffer;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int WPR   = W / 4;
  localparam int NPIX  = W * H;
  localparam int NWORD = NPIX / 4;
`ifdef SERPENTINE_EN
  localparam bit SERP = 1'b1;
`else
  localparam bit SERP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic [31:0] base_addr;
  logic        read_req;
  logic [31:0] read_addr;
  logic [31:0] read_data;
  logic        read_valid;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_eol;
  logic        pix_last;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  input_buffer #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .base_addr  (base_addr),
    .read_req   (read_req),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .read_valid (read_valid),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_eol    (pix_eol),
    .pix_last   (pix_last),
    .busy       (busy),
    .done       (done)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       eol;
    logic       last;
  } pix_t;

  pix_t        q_pix[$];
  logic [31:0] q_addr[$];
  logic [31:0] forced[logic [31:0]];
  logic [31:0] cur_base;

  int total = 0;
  int bad   = 0;
  int epoch = 0;
  int rsp_lat = 1;
  int rdy_pct = 100;
  int stall_cnt = 0;
  int n_xfer, n_eol, n_last, n_reads, n_done;
  bit got_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s: got 0x%0h with nothing expected", name, act);
  endtask

  // Reference: the image is H rows of WPR words; odd rows reversed when serpentine.
  task automatic model_start(input logic [31:0] b);
    cur_base = b;
    q_addr.delete();
    q_pix.delete();
    for (int r = 0; r < H; r++) begin
      for (int j = 0; j < WPR; j++) begin
        int w;
        w = r * WPR + ((SERP && (r % 2 == 1)) ? (WPR - 1 - j) : j);
        q_addr.push_back(b + 32'(4 * w));
      end
    end
  endtask

  task automatic model_word(input logic [31:0] a, input logic [31:0] d);
    int w, r, pos, j;
    bit odd;
    w   = int'((a - cur_base) >> 2);
    r   = w / WPR;
    pos = w % WPR;
    odd = SERP && (r % 2 == 1);
    j   = odd ? (WPR - 1 - pos) : pos;
    for (int p = 0; p < 4; p++) begin
      pix_t e;
      int k, c;
      k      = odd ? (3 - p) : p;
      c      = 4 * j + p;
      e.data = d[31 - 8 * k -: 8];
      e.eol  = (c == W - 1);
      e.last = e.eol && (r == H - 1);
      q_pix.push_back(e);
    end
  endtask

  // SRAM responder.
  initial begin
    read_valid = 1'b0;
    read_data  = '0;
    forever begin
      @(negedge clk);
      if (n_rst === 1'b1 && read_req === 1'b1) begin
        logic [31:0] a, d;
        int ep, lat;
        a   = read_addr;
        ep  = epoch;
        lat = (rsp_lat > 0) ? rsp_lat : int'($urandom_range(3, 1));
        d   = forced.exists(a) ? forced[a] : $urandom;
        repeat (lat) @(posedge clk);
        #1;
        read_valid = 1'b1;
        read_data  = d;
        if (ep == epoch) model_word(a, d);
        @(posedge clk);
        #1;
        read_valid = 1'b0;
        read_data  = $urandom;
        @(negedge clk);
        if (ep == epoch) check("pix_latency", pix_valid, 1);
      end
    end
  end

  // Consumer backpressure.
  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_cnt > 0) begin
        pix_ready = 1'b0;
        stall_cnt--;
      end else begin
        pix_ready = (int'($urandom_range(99)) < rdy_pct);
      end
    end
  end

  // Monitor: address and pixel scoreboards, hold-while-stalled, done ordering.
  initial begin
    pix_t prev, e;
    bit   prev_stall;
    prev_stall = 1'b0;
    prev       = '0;
    forever begin
      @(negedge clk);
      if (n_rst !== 1'b1) begin
        prev_stall = 1'b0;
      end else begin
        if (read_req) begin
          n_reads++;
          if (q_addr.size() == 0) fail("read_unexpected", read_addr);
          else check("read_addr", read_addr, q_addr.pop_front());
        end
        if (prev_stall)
          check("stall_hold", {pix_valid, pix_data, pix_eol, pix_last}, {1'b1, prev});
        if (pix_valid && pix_ready) begin
          n_xfer++;
          if (pix_eol) n_eol++;
          if (pix_last) begin
            n_last++;
            got_last = 1'b1;
          end
          if (q_pix.size() == 0) begin
            fail("pix_unexpected", pix_data);
          end else begin
            e = q_pix.pop_front();
            check("pix", {pix_data, pix_eol, pix_last}, e);
          end
        end
        prev_stall = pix_valid && !pix_ready;
        prev       = {pix_data, pix_eol, pix_last};
        if (done) begin
          n_done++;
          check("done_after_last", {got_last, q_pix.size() == 0}, 2'b11);
        end
      end
    end
  end

  task automatic run_start(input logic [31:0] b);
    @(posedge clk);
    #1;
    base_addr = b;
    start     = 1'b1;
    model_start(b);
    n_xfer = 0; n_eol = 0; n_last = 0; n_reads = 0; n_done = 0;
    got_last = 1'b0;
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = $urandom;
    @(negedge clk);
    check("req_latency", read_req, 1);
    check("start_addr", read_addr, b);
    check("busy_on", busy, 1);
  endtask

  task automatic finish_image();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) fail("done_timeout", 0);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_off", busy, 0);
    check("xfers", n_xfer, NPIX);
    check("reads", n_reads, NWORD);
    check("eols", n_eol, H);
    check("lasts", n_last, 1);
    check("dones", n_done, 1);
  endtask

  initial begin
    bit seen;
    n_rst     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs",
          {read_req, read_addr, pix_data, pix_valid, pix_eol, pix_last, busy, done}, 0);
    @(posedge clk);
    #1 n_rst = 1'b1;

    // Directed first word, single-cycle SRAM, consumer always ready.
    forced[32'h100] = 32'hAABB_CCDD;
    rdy_pct = 100;
    rsp_lat = 1;
    run_start(32'h100);
    finish_image();

    // Random backpressure, address wrap, ignored start while busy.
    rdy_pct = 60;
    rsp_lat = 0;
    run_start(32'hFFFF_FFF0);
    repeat (10) @(posedge clk);
    #1;
    base_addr = 32'hDEAD_0000;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("busy_mid", busy, 1);
    finish_image();

    // Five-cycle stall right after the first pixel of a word.
    rdy_pct = 100;
    run_start(32'h2000);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = pix_valid && pix_ready;
    end
    if (!seen) fail("xfer_timeout", 0);
    stall_cnt = 5;
    finish_image();

    // Reset while waiting for SRAM data; the late response must be ignored.
    rsp_lat = 4;
    run_start(32'h4000);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = read_req;
    end
    if (!seen) fail("req_timeout", 0);
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    epoch++;
    q_addr.delete();
    q_pix.delete();
    @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs",
          {read_req, read_addr, pix_data, pix_valid, pix_eol, pix_last, busy, done}, 0);
    repeat (8) @(negedge clk);
    check("stale_ignored", {busy, pix_valid}, 0);
    rsp_lat = 0;
    rdy_pct = 75;
    run_start(32'h3000);
    finish_image();

    // Base zero with a known word in row 1 (first word of a mirrored row).
    forced[32'hC] = 32'h0102_0304;
    rdy_pct = 80;
    run_start(32'h0);
    finish_image();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
